// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM encoding and the default
// datapath width used by the ALU and HI/LO path.
package div_pkg;

  localparam int unsigned DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// One combinational non-restoring division step on the {A,Q} pair.
// The add/subtract choice follows the sign of A before the shift.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH:0]   a_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH:0]   m_i,
  output logic [WIDTH:0]   a_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   a_sh;
  logic [WIDTH-1:0] q_sh;

  always_comb begin
    a_sh = {a_i[WIDTH-1:0], q_i[WIDTH-1]};
    q_sh = {q_i[WIDTH-2:0], 1'b0};
    if (a_i[WIDTH]) begin
      a_o = a_sh + m_i;
    end else begin
      a_o = a_sh - m_i;
    end
    // Quotient bit is 1 whenever the new partial remainder is non-negative.
    q_o = {q_sh[WIDTH-1:1], ~a_o[WIDTH]};
  end

endmodule

// File: rtl/div_seq.sv
// Multi-cycle non-restoring divider, one quotient bit per clock, with signed
// mode and divide-by-zero handling. Result is packed {remainder, quotient}.
module div_seq
  import div_pkg::*;
#(
  parameter  int unsigned WIDTH = DIV_WIDTH,
  localparam int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic                 start,
  input  logic                 is_signed,
  input  logic [WIDTH-1:0]     dividend,
  input  logic [WIDTH-1:0]     divisor,
  output logic                 busy,
  output logic                 done,
  output logic                 div_by_zero,
  output logic [2*WIDTH-1:0]   QR
);

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

  div_state_e       state;
  logic [WIDTH:0]   a_q;
  logic [WIDTH:0]   m_q;
  logic [WIDTH-1:0] q_q;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_quo_q;
  logic             neg_rem_q;
  logic             dbz_q;

  logic             dvd_neg;
  logic             dvs_neg;
  logic [WIDTH-1:0] dvd_mag;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   a_step;
  logic [WIDTH-1:0] q_step;
  logic [WIDTH:0]   a_fix;
  logic [WIDTH-1:0] rem_mag;
  logic [WIDTH-1:0] rem_res;
  logic [WIDTH-1:0] quo_res;

  // Operand magnitudes; unsigned mode passes the raw bits through.
  always_comb begin
    dvd_neg = is_signed & dividend[WIDTH-1];
    dvs_neg = is_signed & divisor[WIDTH-1];
    dvd_mag = dvd_neg ? (~dividend + 1'b1) : dividend;
    dvs_mag = dvs_neg ? (~divisor + 1'b1) : divisor;
  end

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .a_i(a_q),
    .q_i(q_q),
    .m_i(m_q),
    .a_o(a_step),
    .q_o(q_step)
  );

  // Final remainder restore and C-style sign correction.
  always_comb begin
    a_fix   = a_q[WIDTH] ? (a_q + m_q) : a_q;
    rem_mag = a_fix[WIDTH-1:0];
    rem_res = neg_rem_q ? (~rem_mag + 1'b1) : rem_mag;
    quo_res = neg_quo_q ? (~q_q + 1'b1) : q_q;
  end

  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      a_q         <= '0;
      m_q         <= '0;
      q_q         <= '0;
      cnt_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      dbz_q       <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      QR          <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy      <= 1'b1;
            neg_quo_q <= dvd_neg ^ dvs_neg;
            neg_rem_q <= dvd_neg;
            a_q       <= '0;
            m_q       <= {1'b0, dvs_mag};
            cnt_q     <= CNT_INIT;
            if (divisor == '0) begin
              // Raw dividend parks in Q; it becomes the remainder in FIX.
              dbz_q <= 1'b1;
              q_q   <= dividend;
              state <= FIX;
            end else begin
              dbz_q <= 1'b0;
              q_q   <= dvd_mag;
              state <= CALC;
            end
          end
        end
        CALC: begin
          a_q   <= a_step;
          q_q   <= q_step;
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_LAST) begin
            state <= FIX;
          end
        end
        FIX: begin
          busy        <= 1'b0;
          done        <= 1'b1;
          div_by_zero <= dbz_q;
          if (dbz_q) begin
            QR <= {q_q, {WIDTH{1'b1}}};
          end else begin
            QR <= {rem_res, quo_res};
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: 32-bit instance plus an 8-bit instance.
module tb_div_seq;

  logic        clock = 1'b0;
  logic        clear = 1'b1;
  logic        start = 1'b0;
  logic        is_signed = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [63:0] QR;

  logic        s8_start = 1'b0;
  logic        s8_is_signed = 1'b0;
  logic [7:0]  s8_dividend = '0;
  logic [7:0]  s8_divisor = '0;
  logic        s8_busy;
  logic        s8_done;
  logic        s8_div_by_zero;
  logic [15:0] s8_QR;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  div_seq #(.WIDTH(32)) dut (
    .clock(clock), .clear(clear), .start(start), .is_signed(is_signed),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .QR(QR)
  );

  div_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .clear(clear), .start(s8_start), .is_signed(s8_is_signed),
    .dividend(s8_dividend), .divisor(s8_divisor), .busy(s8_busy), .done(s8_done),
    .div_by_zero(s8_div_by_zero), .QR(s8_QR)
  );

  // Starts one operation (called just after a rising edge) and waits for done.
  // lat counts the start edge as cycle 1; busy_n counts samples with busy high.
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output int lat, output int busy_n);
    is_signed = sgn;
    dividend  = a;
    divisor   = b;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start     = 1'b0;
    dividend  = $urandom;
    divisor   = $urandom;
    is_signed = ~sgn;
    lat       = 1;
    busy_n    = 0;
    while (!done && lat < 100) begin
      if (busy) busy_n++;
      @(posedge clock);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clock);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || QR !== 64'd0) begin
      failures++;
      $display("FAIL reset_during: busy=%b done=%b dbz=%b QR=%h want 0", busy, done,
               div_by_zero, QR);
    end
    clear = 1'b0;
    @(posedge clock);
    #1;
    checks++;
    if ({busy, done, div_by_zero} !== 3'b000 || QR !== 64'd0) begin
      failures++;
      $display("FAIL reset_after: busy=%b done=%b dbz=%b QR=%h want 0", busy, done,
               div_by_zero, QR);
    end
  endtask

  task automatic test_signed();
    int lat, bn;
    do_div(1'b1, 32'd100, 32'd7, lat, bn);
    checks++;
    if (lat !== 34 || bn !== 33 || busy !== 1'b0) begin
      failures++;
      $display("FAIL s100_7_timing: lat=%0d busy_cycles=%0d busy=%b want 34 33 0", lat, bn, busy);
    end
    checks++;
    if (QR !== {32'd2, 32'd14} || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL s100_7: QR=%h dbz=%b want %h 0", QR, div_by_zero, {32'd2, 32'd14});
    end
    @(posedge clock);
    #1;
    do_div(1'b1, 32'hFFFF_FF9C, 32'd7, lat, bn);
    checks++;
    if (QR !== {32'hFFFF_FFFE, 32'hFFFF_FFF2}) begin
      failures++;
      $display("FAIL sm100_7: QR=%h want %h", QR, {32'hFFFF_FFFE, 32'hFFFF_FFF2});
    end
    @(posedge clock);
    #1;
    do_div(1'b1, 32'd100, 32'hFFFF_FFF9, lat, bn);
    checks++;
    if (QR !== {32'h0000_0002, 32'hFFFF_FFF2}) begin
      failures++;
      $display("FAIL s100_m7: QR=%h want %h", QR, {32'h0000_0002, 32'hFFFF_FFF2});
    end
  endtask

  task automatic test_unsigned();
    int lat, bn;
    @(posedge clock);
    #1;
    do_div(1'b0, 32'hFFFF_FFFF, 32'd2, lat, bn);
    checks++;
    if (QR !== {32'd1, 32'h7FFF_FFFF} || lat !== 34) begin
      failures++;
      $display("FAIL u_ffff_2: QR=%h lat=%0d want %h 34", QR, lat, {32'd1, 32'h7FFF_FFFF});
    end
    @(posedge clock);
    #1;
    do_div(1'b1, 32'hFFFF_FFFF, 32'd2, lat, bn);
    checks++;
    if (QR !== {32'hFFFF_FFFF, 32'd0}) begin
      failures++;
      $display("FAIL s_m1_2: QR=%h want %h", QR, {32'hFFFF_FFFF, 32'd0});
    end
  endtask

  task automatic test_div_by_zero();
    int lat, bn;
    @(posedge clock);
    #1;
    do_div(1'b1, 32'h1234_5678, 32'd0, lat, bn);
    checks++;
    if (lat !== 2 || div_by_zero !== 1'b1 || QR !== {32'h1234_5678, 32'hFFFF_FFFF}) begin
      failures++;
      $display("FAIL dbz: lat=%0d dbz=%b QR=%h want 2 1 %h", lat, div_by_zero, QR,
               {32'h1234_5678, 32'hFFFF_FFFF});
    end
    @(posedge clock);
    #1;
    do_div(1'b0, 32'd9, 32'd3, lat, bn);
    checks++;
    if (div_by_zero !== 1'b0 || QR !== {32'd0, 32'd3}) begin
      failures++;
      $display("FAIL dbz_clear: dbz=%b QR=%h want 0 %h", div_by_zero, QR, {32'd0, 32'd3});
    end
  endtask

  task automatic test_overflow();
    int lat, bn;
    @(posedge clock);
    #1;
    do_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bn);
    checks++;
    if (QR !== {32'd0, 32'h8000_0000} || div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL min_m1: QR=%h dbz=%b want %h 0", QR, div_by_zero, {32'd0, 32'h8000_0000});
    end
    @(posedge clock);
    #1;
    do_div(1'b1, 32'h8000_0000, 32'd1, lat, bn);
    checks++;
    if (QR !== {32'd0, 32'h8000_0000}) begin
      failures++;
      $display("FAIL min_1: QR=%h want %h", QR, {32'd0, 32'h8000_0000});
    end
  endtask

  task automatic test_back_to_back();
    int lat, bn;
    @(posedge clock);
    #1;
    do_div(1'b0, 32'd20, 32'd6, lat, bn);
    checks++;
    if (QR !== {32'd2, 32'd3} || done !== 1'b1) begin
      failures++;
      $display("FAIL b2b_first: QR=%h done=%b want %h 1", QR, done, {32'd2, 32'd3});
    end
    // Issued in the done cycle of the previous op.
    do_div(1'b0, 32'd7, 32'd2, lat, bn);
    checks++;
    if (QR !== {32'd1, 32'd3} || lat !== 34) begin
      failures++;
      $display("FAIL b2b_second: QR=%h lat=%0d want %h 34", QR, lat, {32'd1, 32'd3});
    end
  endtask

  task automatic test_ignore_start();
    int dones;
    logic [63:0] prev, got;
    logic held;
    @(posedge clock);
    #1;
    prev      = QR;
    is_signed = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'd7;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    dones = 0;
    got   = '0;
    held  = 1'b1;
    for (int i = 2; i <= 45; i++) begin
      if (i == 5) begin
        dividend = 32'd50;
        divisor  = 32'd5;
        start    = 1'b1;
      end
      if (i == 6) start = 1'b0;
      @(posedge clock);
      #1;
      if (done) begin
        dones++;
        got = QR;
      end else if (dones == 0 && QR !== prev) begin
        held = 1'b0;
      end
    end
    checks++;
    if (dones !== 1 || got !== {32'd2, 32'd14}) begin
      failures++;
      $display("FAIL ignore_start: dones=%0d QR=%h want 1 %h", dones, got, {32'd2, 32'd14});
    end
    checks++;
    if (held !== 1'b1) begin
      failures++;
      $display("FAIL qr_hold_calc: held=%b want 1", held);
    end
  endtask

  task automatic test_clear();
    int dones;
    @(posedge clock);
    #1;
    is_signed = 1'b1;
    dividend  = 32'd100;
    divisor   = 32'hFFFF_FFF9;
    start     = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clock);
    #3;
    clear = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || QR !== 64'd0 || done !== 1'b0) begin
      failures++;
      $display("FAIL async_clear: busy=%b QR=%h done=%b want 0 0 0", busy, QR, done);
    end
    @(posedge clock);
    #1;
    clear = 1'b0;
    dones = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (done) dones++;
    end
    checks++;
    if (dones !== 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL clear_no_done: dones=%0d busy=%b want 0 0", dones, busy);
    end
  endtask

  task automatic test_width8();
    int lat;
    @(posedge clock);
    #1;
    s8_is_signed = 1'b0;
    s8_dividend  = 8'd200;
    s8_divisor   = 8'd13;
    s8_start     = 1'b1;
    @(posedge clock);
    #1;
    s8_start = 1'b0;
    lat = 1;
    while (!s8_done && lat < 40) begin
      @(posedge clock);
      #1;
      lat++;
    end
    checks++;
    if (s8_QR !== {8'd5, 8'd15} || lat !== 10 || s8_div_by_zero !== 1'b0) begin
      failures++;
      $display("FAIL w8_200_13: QR=%h lat=%0d dbz=%b want %h 10 0", s8_QR, lat, s8_div_by_zero,
               {8'd5, 8'd15});
    end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_div_by_zero();
    test_overflow();
    test_back_to_back();
    test_ignore_start();
    test_clear();
    test_width8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
